// File: rtl/dsp_cfg_mgmt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dsp_cfg_mgmt_arbiter
// Description : Round-robin arbiter and access sequencer for the DSP
//               configuration management port. Requester 0 is the routed
//               CFG-request path, requester 1 is the local header poller.
//               Each access is issued, held until done (or timed out),
//               and answered with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_cfg_mgmt_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        dsp_user_clk,
    input  logic        sys_reset_n,
    input  logic        r0_req,
    input  logic        r0_write,
    input  logic [9:0]  r0_addr,
    input  logic [15:0] r0_function_number,
    input  logic [31:0] r0_write_data,
    input  logic [3:0]  r0_byte_enable,
    input  logic        r1_req,
    input  logic        r1_write,
    input  logic [9:0]  r1_addr,
    input  logic [15:0] r1_function_number,
    input  logic [31:0] r1_write_data,
    input  logic [3:0]  r1_byte_enable,
    output logic        r0_done,
    output logic        r1_done,
    output logic        rsp_err,
    output logic [31:0] rsp_read_data,
    output logic        busy,
    output logic        grant_id,
    output logic [9:0]  cfg_mgmt_addr,
    output logic [15:0] cfg_mgmt_function_number,
    output logic [31:0] cfg_mgmt_write_data,
    output logic [3:0]  cfg_mgmt_byte_enable,
    output logic        cfg_mgmt_write,
    output logic        cfg_mgmt_read,
    output logic        cfg_mgmt_debug_access,
    input  logic [31:0] cfg_mgmt_read_data,
    input  logic        cfg_mgmt_read_write_done
);

    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES <= 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Last ACTIVE cycle index before a forced completion (unused when disabled).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [9:0]         addr_q, addr_d;
    logic [15:0]        fn_q, fn_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               grant_sel;
    logic               active;

    // Next-state logic: arbitration in IDLE, done/timeout handling in ACTIVE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        fn_d         = fn_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rsp_err_d    = rsp_err_q;
        rsp_data_d   = rsp_data_q;
        // Contention goes to whoever did not win last; otherwise the lone requester.
        grant_sel    = (r0_req && r1_req) ? ~last_grant_q : r1_req;

        case (state_q)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    grant_id_d   = grant_sel;
                    last_grant_d = grant_sel;
                    cnt_d        = '0;
                    wr_d         = grant_sel ? r1_write           : r0_write;
                    addr_d       = grant_sel ? r1_addr            : r0_addr;
                    fn_d         = grant_sel ? r1_function_number : r0_function_number;
                    wdata_d      = grant_sel ? r1_write_data      : r0_write_data;
                    be_d         = grant_sel ? r1_byte_enable     : r0_byte_enable;
                    state_d      = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // A real completion beats a timeout landing in the same cycle.
                if (cfg_mgmt_read_write_done) begin
                    rsp_err_d  = 1'b0;
                    rsp_data_d = wr_q ? 32'h0 : cfg_mgmt_read_data;
                    state_d    = ST_COMPLETE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 32'hFFFF_FFFF;
                    state_d    = ST_COMPLETE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; last_grant resets to 1 so r0 wins first.
    always_ff @(posedge dsp_user_clk) begin
        if (!sys_reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            fn_q         <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            fn_q         <= fn_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rsp_err_q    <= rsp_err_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // Command fields are only visible to the DSP while the access is in flight.
    assign active                   = (state_q == ST_ACTIVE);
    assign cfg_mgmt_write           = active & wr_q;
    assign cfg_mgmt_read            = active & ~wr_q;
    assign cfg_mgmt_addr            = active ? addr_q  : 10'h0;
    assign cfg_mgmt_function_number = active ? fn_q    : 16'h0;
    assign cfg_mgmt_write_data      = active ? wdata_q : 32'h0;
    assign cfg_mgmt_byte_enable     = active ? be_q    : 4'h0;
    assign cfg_mgmt_debug_access    = 1'b0;

    assign r0_done       = (state_q == ST_COMPLETE) & ~grant_id_q;
    assign r1_done       = (state_q == ST_COMPLETE) &  grant_id_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_read_data = rsp_data_q;
    assign busy          = (state_q != ST_IDLE);
    assign grant_id      = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_cfg_mgmt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_cfg_mgmt_arbiter
// Description : Self-checking bench for dsp_cfg_mgmt_arbiter with directed
//               scenarios and a randomized round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_cfg_mgmt_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req = 0, r0_write = 0, r1_req = 0, r1_write = 0;
    logic [9:0]  r0_addr = 0, r1_addr = 0;
    logic [15:0] r0_fn = 0, r1_fn = 0;
    logic [31:0] r0_wd = 0, r1_wd = 0;
    logic [3:0]  r0_be = 0, r1_be = 0;
    logic        r0_done, r1_done, rsp_err, busy, grant_id;
    logic [31:0] rsp_read_data;
    logic [9:0]  m_addr;
    logic [15:0] m_fn;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    logic        m_wr, m_rd, m_dbg;
    logic [31:0] cfg_rdata = 0;
    logic        cfg_done = 0;

    int checks = 0, errors = 0, cyc = 0;

    // Per-access observations filled in by run_access.
    int          o_ns, o_nd0, o_nd1, o_fc;
    logic        o_g, o_ws, o_rs, o_err, o_busy_after;
    logic [9:0]  o_a;
    logic [15:0] o_f;
    logic [31:0] o_wd, o_rdat;
    logic [3:0]  o_be;
    bit          o_stable, o_clean, o_ok;

    // Expected request fields per requester.
    logic        ew[2];
    logic [9:0]  ea[2];
    logic [15:0] ef[2];
    logic [31:0] ewd[2];
    logic [3:0]  ebe[2];

    dsp_cfg_mgmt_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .dsp_user_clk(clk), .sys_reset_n(rst_n),
        .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr),
        .r0_function_number(r0_fn), .r0_write_data(r0_wd), .r0_byte_enable(r0_be),
        .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr),
        .r1_function_number(r1_fn), .r1_write_data(r1_wd), .r1_byte_enable(r1_be),
        .r0_done(r0_done), .r1_done(r1_done), .rsp_err(rsp_err),
        .rsp_read_data(rsp_read_data), .busy(busy), .grant_id(grant_id),
        .cfg_mgmt_addr(m_addr), .cfg_mgmt_function_number(m_fn),
        .cfg_mgmt_write_data(m_wd), .cfg_mgmt_byte_enable(m_be),
        .cfg_mgmt_write(m_wr), .cfg_mgmt_read(m_rd), .cfg_mgmt_debug_access(m_dbg),
        .cfg_mgmt_read_data(cfg_rdata), .cfg_mgmt_read_write_done(cfg_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout got stuck exp finish");
        $fatal(1, "bench did not finish");
    end

    task automatic set_req(input int q, input logic w, input logic [9:0] a, input logic [15:0] f,
                           input logic [31:0] d, input logic [3:0] b);
        ew[q] = w; ea[q] = a; ef[q] = f; ewd[q] = d; ebe[q] = b;
        if (q == 0) begin
            r0_write = w; r0_addr = a; r0_fn = f; r0_wd = d; r0_be = b; r0_req = 1'b1;
        end else begin
            r1_write = w; r1_addr = a; r1_fn = f; r1_wd = d; r1_be = b; r1_req = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Plays the DSP side for one access: done after dly strobe cycles (0 = never),
    // optionally disturbs the granted requester's fields, drops req on its done.
    task automatic run_access(input int dly, input logic [31:0] rd, input bit scramble);
        bit fin = 0;
        o_ns = 0; o_nd0 = 0; o_nd1 = 0; o_fc = -1; o_g = 0; o_ws = 0; o_rs = 0;
        o_a = 0; o_f = 0; o_wd = 0; o_be = 0; o_stable = 1; o_clean = 0; o_ok = 0;
        o_err = 0; o_rdat = 0; o_busy_after = 1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            cfg_done  = 1'b0;
            cfg_rdata = $urandom;
            o_nd0 += int'(r0_done);
            o_nd1 += int'(r1_done);
            if (fin) begin
                o_busy_after = busy;
                o_ok = 1;
                break;
            end
            if (m_wr || m_rd) begin
                o_ns++;
                if (o_ns == 1) begin
                    o_fc = cyc; o_g = grant_id; o_ws = m_wr; o_rs = m_rd;
                    o_a = m_addr; o_f = m_fn; o_wd = m_wd; o_be = m_be;
                    if (scramble) begin
                        if (!o_g) begin
                            r0_addr ^= 10'h016; r0_fn = ~r0_fn; r0_wd = ~r0_wd; r0_be = ~r0_be; r0_write = ~r0_write;
                        end else begin
                            r1_addr ^= 10'h016; r1_fn = ~r1_fn; r1_wd = ~r1_wd; r1_be = ~r1_be; r1_write = ~r1_write;
                        end
                    end
                end else if ({m_wr, m_rd, m_addr, m_fn, m_wd, m_be} !== {o_ws, o_rs, o_a, o_f, o_wd, o_be}) begin
                    o_stable = 0;
                end
                if (o_ns == dly) begin
                    cfg_done  = 1'b1;
                    cfg_rdata = rd;
                end
            end
            if (r0_done || r1_done) begin
                o_err   = rsp_err;
                o_rdat  = rsp_read_data;
                o_clean = ({m_wr, m_rd, m_addr, m_fn, m_wd, m_be} === '0);
                if (r0_done) r0_req = 1'b0;
                if (r1_done) r1_req = 1'b0;
                fin = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id got %0h exp 0", grant_id); end
        checks++; if ({r0_done, r1_done, rsp_err} !== 3'b0) begin errors++; $display("FAIL reset_done_err got %0h exp 0", {r0_done, r1_done, rsp_err}); end
        checks++; if (rsp_read_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %0h exp 0", rsp_read_data); end
        checks++; if ({m_wr, m_rd, m_dbg, m_addr, m_fn, m_wd, m_be} !== '0) begin errors++; $display("FAIL reset_cfg_outputs got %0h exp 0", {m_wr, m_rd, m_dbg, m_addr, m_fn, m_wd, m_be}); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        set_req(0, 1'b0, 10'h006, 16'h0000, 32'h1234_5678, 4'hF);
        run_access(3, 32'h0002_0100, 0);
        checks++; if (!o_ok) begin errors++; $display("FAIL single_read_complete got 0 exp 1"); end
        checks++; if (o_ns !== 3) begin errors++; $display("FAIL single_read_strobe_len got %0d exp 3", o_ns); end
        checks++; if ({o_rs, o_ws} !== 2'b10) begin errors++; $display("FAIL single_read_strobes got %0b exp 10", {o_rs, o_ws}); end
        checks++; if (o_a !== 10'h006) begin errors++; $display("FAIL single_read_addr got %0h exp 6", o_a); end
        checks++; if (o_nd0 !== 1 || o_nd1 !== 0) begin errors++; $display("FAIL single_read_dones got %0d/%0d exp 1/0", o_nd0, o_nd1); end
        checks++; if (o_rdat !== 32'h0002_0100 || o_err !== 1'b0) begin errors++; $display("FAIL single_read_rsp got %0h err %0h exp 20100 err 0", o_rdat, o_err); end
        checks++; if (!o_clean || o_busy_after !== 1'b0) begin errors++; $display("FAIL single_read_complete_idle got clean %0d busy %0h exp 1 0", o_clean, o_busy_after); end
    endtask

    task automatic test_simultaneous();
        int fc0;
        pulse_reset();
        set_req(0, 1'b0, 10'h011, 16'h0003, 32'h0, 4'hF);
        set_req(1, 1'b0, 10'h022, 16'h0004, 32'h0, 4'hF);
        run_access(2, 32'hA5A5_0001, 0);
        fc0 = o_fc;
        checks++; if (o_g !== 1'b0 || o_a !== 10'h011 || o_nd0 !== 1 || o_nd1 !== 0) begin errors++; $display("FAIL simul_first got g%0h a%0h d%0d/%0d exp g0 a11 d1/0", o_g, o_a, o_nd0, o_nd1); end
        run_access(4, 32'hA5A5_0002, 0);
        checks++; if (o_g !== 1'b1 || o_a !== 10'h022 || o_nd1 !== 1 || o_nd0 !== 0) begin errors++; $display("FAIL simul_second got g%0h a%0h d%0d/%0d exp g1 a22 d0/1", o_g, o_a, o_nd0, o_nd1); end
        checks++; if (o_fc - fc0 !== 4) begin errors++; $display("FAIL simul_issue_interval got %0d exp 4", o_fc - fc0); end
        checks++; if (o_rdat !== 32'hA5A5_0002) begin errors++; $display("FAIL simul_rsp got %0h exp a5a50002", o_rdat); end
    endtask

    task automatic test_write();
        set_req(1, 1'b1, 10'h1A5, 16'h0001, 32'h00FF_0100, 4'hF);
        run_access(2, 32'hDEAD_BEEF, 0);
        checks++; if ({o_ws, o_rs} !== 2'b10) begin errors++; $display("FAIL write_strobes got %0b exp 10", {o_ws, o_rs}); end
        checks++; if ({o_a, o_f, o_wd, o_be} !== {10'h1A5, 16'h0001, 32'h00FF_0100, 4'hF}) begin errors++; $display("FAIL write_fields got %0h exp %0h", {o_a, o_f, o_wd, o_be}, {10'h1A5, 16'h0001, 32'h00FF_0100, 4'hF}); end
        checks++; if (o_rdat !== 32'h0 || o_err !== 1'b0) begin errors++; $display("FAIL write_rsp got %0h err %0h exp 0 0", o_rdat, o_err); end
        checks++; if (o_nd1 !== 1 || o_nd0 !== 0) begin errors++; $display("FAIL write_dones got %0d/%0d exp 0/1", o_nd0, o_nd1); end
    endtask

    task automatic test_timeout();
        set_req(0, 1'b0, 10'h033, 16'h0, 32'h0, 4'hF);
        run_access(0, 32'h0, 0);
        checks++; if (o_ns !== TO) begin errors++; $display("FAIL timeout_strobe_len got %0d exp %0d", o_ns, TO); end
        checks++; if (o_err !== 1'b1 || o_rdat !== 32'hFFFF_FFFF || o_nd0 !== 1) begin errors++; $display("FAIL timeout_rsp got err %0h %0h d%0d exp 1 ffffffff d1", o_err, o_rdat, o_nd0); end
        set_req(0, 1'b0, 10'h034, 16'h0, 32'h0, 4'hF);
        run_access(1, 32'h1111_2222, 0);
        checks++; if (o_ns !== 1 || o_err !== 1'b0 || o_rdat !== 32'h1111_2222) begin errors++; $display("FAIL timeout_recovery got n%0d err %0h %0h exp n1 0 11112222", o_ns, o_err, o_rdat); end
        set_req(0, 1'b0, 10'h035, 16'h0, 32'h0, 4'hF);
        run_access(TO, 32'h3333_4444, 0);
        checks++; if (o_ns !== TO || o_err !== 1'b0 || o_rdat !== 32'h3333_4444) begin errors++; $display("FAIL timeout_done_same_cycle got n%0d err %0h %0h exp n%0d 0 33334444", o_ns, o_err, o_rdat, TO); end
    endtask

    task automatic test_field_change();
        set_req(0, 1'b0, 10'h006, 16'h0002, 32'h0, 4'h3);
        run_access(5, 32'h0BAD_F00D, 1);
        checks++; if (o_a !== 10'h006 || !o_stable) begin errors++; $display("FAIL field_change_addr got %0h stable %0d exp 6 1", o_a, o_stable); end
        checks++; if (o_rdat !== 32'h0BAD_F00D || o_nd0 !== 1) begin errors++; $display("FAIL field_change_rsp got %0h d%0d exp badf00d d1", o_rdat, o_nd0); end
    endtask

    task automatic test_reset_mid_active();
        int n = 0;
        bit got = 0;
        set_req(0, 1'b0, 10'h006, 16'h0, 32'h0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (m_rd || m_wr) n++;
            if (n == 2) begin got = 1; break; end
        end
        checks++; if (!got) begin errors++; $display("FAIL rst_mid_reach_active got 0 exp 1"); end
        rst_n = 1'b0;
        set_req(1, 1'b0, 10'h077, 16'h0, 32'h0, 4'hF);
        @(posedge clk); #1;
        checks++; if ({m_wr, m_rd, busy, r0_done, r1_done, grant_id, rsp_err} !== 7'b0) begin errors++; $display("FAIL rst_mid_ctrl got %0b exp 0", {m_wr, m_rd, busy, r0_done, r1_done, grant_id, rsp_err}); end
        checks++; if (rsp_read_data !== 32'h0 || m_addr !== 10'h0) begin errors++; $display("FAIL rst_mid_data got %0h/%0h exp 0/0", rsp_read_data, m_addr); end
        rst_n = 1'b1;
        run_access(2, 32'h5555_0000, 0);
        checks++; if (o_g !== 1'b0 || o_nd0 !== 1) begin errors++; $display("FAIL rst_mid_r0_wins got g%0h d%0d exp g0 d1", o_g, o_nd0); end
        run_access(1, 32'h5555_0001, 0);
        checks++; if (o_g !== 1'b1 || o_a !== 10'h077) begin errors++; $display("FAIL rst_mid_r1_next got g%0h a%0h exp g1 a77", o_g, o_a); end
    endtask

    task automatic test_done_outside();
        int nd = 0;
        for (int i = 0; i < 4; i++) begin
            cfg_done  = (i < 2);
            cfg_rdata = 32'hCAFE_0000;
            @(posedge clk); #1;
            nd += int'(r0_done) + int'(r1_done) + int'(busy);
        end
        cfg_done = 1'b0;
        checks++; if (nd !== 0) begin errors++; $display("FAIL done_outside_activity got %0d exp 0", nd); end
        checks++; if (rsp_read_data !== 32'h5555_0001) begin errors++; $display("FAIL done_outside_rsp got %0h exp 55550001", rsp_read_data); end
    endtask

    task automatic test_random();
        logic last = 1'b1;
        logic win;
        int d, exp_ns;
        logic exp_err;
        logic [31:0] rd, exp_rd;
        pulse_reset();
        for (int it = 0; it < 60; it++) begin
            if (!r0_req && $urandom_range(0, 2) != 0)
                set_req(0, 1'($urandom_range(0, 1)), 10'($urandom), 16'($urandom), $urandom, 4'($urandom));
            if (!r1_req && $urandom_range(0, 2) != 0)
                set_req(1, 1'($urandom_range(0, 1)), 10'($urandom), 16'($urandom), $urandom, 4'($urandom));
            if (!r0_req && !r1_req)
                set_req(0, 1'($urandom_range(0, 1)), 10'($urandom), 16'($urandom), $urandom, 4'($urandom));
            win = (r0_req && r1_req) ? !last : r1_req;
            d   = $urandom_range(0, 10);
            rd  = $urandom;
            run_access(d, rd, 1'($urandom_range(0, 1)));
            exp_err = !(d >= 1 && d <= TO);
            exp_ns  = exp_err ? TO : d;
            exp_rd  = exp_err ? 32'hFFFF_FFFF : (ew[win] ? 32'h0 : rd);
            checks++; if (!o_ok || o_g !== win || (win ? o_nd1 : o_nd0) !== 1 || (win ? o_nd0 : o_nd1) !== 0) begin errors++; $display("FAIL rand_grant it%0d got ok%0d g%0h d%0d/%0d exp g%0h", it, o_ok, o_g, o_nd0, o_nd1, win); end
            checks++; if ({o_ws, o_rs, o_a, o_f, o_wd, o_be} !== {ew[win], !ew[win], ea[win], ef[win], ewd[win], ebe[win]} || !o_stable) begin errors++; $display("FAIL rand_fields it%0d got %0h exp %0h", it, {o_ws, o_rs, o_a, o_f, o_wd, o_be}, {ew[win], !ew[win], ea[win], ef[win], ewd[win], ebe[win]}); end
            checks++; if (o_ns !== exp_ns || o_err !== exp_err || o_rdat !== exp_rd || !o_clean) begin errors++; $display("FAIL rand_rsp it%0d got n%0d err%0h %0h exp n%0d err%0h %0h", it, o_ns, o_err, o_rdat, exp_ns, exp_err, exp_rd); end
            last = win;
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write();
        test_timeout();
        test_field_change();
        test_reset_mid_active();
        test_done_outside();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
